// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with ENA/RDY methods (enq, deq, first, clear),
// occupancy count and almost-full/almost-empty status.
module param_fifo #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enq__ENA,
  input  logic [WIDTH-1:0]         enq_v,
  output logic                     enq__RDY,
  input  logic                     deq__ENA,
  output logic                     deq__RDY,
  output logic [WIDTH-1:0]         first,
  output logic                     first__RDY,
  input  logic                     clear__ENA,
  output logic                     clear__RDY,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic             not_full;
  logic             not_empty;
  logic             enq_fire;
  logic             deq_fire;
  logic             flush;

  assign not_full  = (occ != CW'(DEPTH));
  assign not_empty = (occ != CW'(0));
  assign enq_fire  = enq__ENA && not_full;
  assign deq_fire  = deq__ENA && not_empty;
  assign flush     = RST || clear__ENA;

  // Status outputs depend only on registered state.
  assign enq__RDY     = not_full;
  assign deq__RDY     = not_empty;
  assign first__RDY   = not_empty;
  assign clear__RDY   = 1'b1;
  assign count        = occ;
  assign first        = not_empty ? mem[rd_ptr] : '0;
  assign almost_full  = (32'(occ) >= AFULL_LEVEL);
  assign almost_empty = (32'(occ) <= AEMPTY_LEVEL);

  // Pointers and occupancy; reset and clear both empty the queue.
  always_ff @(posedge CLK) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (enq_fire && !flush) mem[wr_ptr] <= enq_v;
  end

endmodule
